// File: rtl/mimc_round_scheduler.sv
// mimc_round_scheduler: interleaves up to ROUND_LATENCY MiMC-BN254 jobs over
// one shared pipelined round unit, recirculating each job N_ROUNDS times and
// finishing with a single key addition mod P.
module mimc_round_scheduler #(
    parameter int unsigned       N_BITS        = 254,
    parameter logic [N_BITS-1:0] P             = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
    parameter int unsigned       N_ROUNDS      = 91,
    parameter int unsigned       ROUND_LATENCY = 40,
    parameter int unsigned       TAG_W         = 6,
    parameter int unsigned       RC_AW         = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [N_BITS-1:0] in_msg,
    input  logic [N_BITS-1:0] in_key,
    output logic [RC_AW-1:0]  rc_addr,
    input  logic [N_BITS-1:0] rc_data,
    output logic [N_BITS-1:0] round_in,
    output logic [N_BITS-1:0] round_rc,
    output logic [N_BITS-1:0] round_key,
    input  logic [N_BITS-1:0] round_out,
    output logic              out_valid,
    output logic [TAG_W-1:0]  out_tag,
    output logic [N_BITS-1:0] out_hash,
    output logic              busy
);

    localparam int unsigned      LAT    = ROUND_LATENCY;
    localparam logic [RC_AW-1:0] LAST_R = RC_AW'(N_ROUNDS - 1);

    // Slot metadata shift register; entry LAT-1 describes the value on round_out.
    logic [LAT-1:0]    slot_valid_q, slot_valid_d;
    logic [RC_AW-1:0]  slot_r_q   [LAT];
    logic [RC_AW-1:0]  slot_r_d   [LAT];
    logic [TAG_W-1:0]  slot_tag_q [LAT];
    logic [TAG_W-1:0]  slot_tag_d [LAT];
    logic [N_BITS-1:0] slot_key_q [LAT];
    logic [N_BITS-1:0] slot_key_d [LAT];

    logic              run_q, run_d;
    logic [N_BITS-1:0] round_in_q, round_in_d;
    logic [N_BITS-1:0] round_rc_q, round_rc_d;
    logic [N_BITS-1:0] round_key_q, round_key_d;
    logic              out_valid_q, out_valid_d;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d;
    logic [N_BITS-1:0] out_hash_q, out_hash_d;

    logic              ret_valid;
    logic [RC_AW-1:0]  ret_r;
    logic [TAG_W-1:0]  ret_tag;
    logic [N_BITS-1:0] ret_key;
    logic              recirc;
    logic              finish;
    logic              accept;
    logic              issue_valid;
    logic [TAG_W-1:0]  issue_tag;
    logic [N_BITS-1:0] issue_key;
    logic [N_BITS:0]   key_sum;
    logic [N_BITS-1:0] key_sum_red;

    assign ret_valid   = slot_valid_q[LAT-1];
    assign ret_r       = slot_r_q[LAT-1];
    assign ret_tag     = slot_tag_q[LAT-1];
    assign ret_key     = slot_key_q[LAT-1];
    // r never exceeds LAST_R, so inequality is the same as "more rounds to go"
    assign recirc      = ret_valid & (ret_r != LAST_R);
    assign finish      = ret_valid & (ret_r == LAST_R);
    // run_q keeps in_ready low during reset and releases it one edge later
    assign in_ready    = run_q & ~recirc;
    assign accept      = in_valid & in_ready;
    assign issue_valid = recirc | accept;
    assign rc_addr     = recirc ? ret_r + RC_AW'(1) : '0;

    // Issue mux: a recirculating slot wins, otherwise a new job or a bubble.
    always_comb begin
        run_d      = 1'b1;
        issue_tag  = in_tag;
        issue_key  = in_key;
        round_in_d = '0;
        if (recirc) begin
            issue_tag  = ret_tag;
            issue_key  = ret_key;
            round_in_d = round_out;
        end else if (accept) begin
            round_in_d = in_msg;
        end
        round_rc_d  = rc_data;
        round_key_d = issue_key;
    end

    // Advance slot metadata in lockstep with the round unit.
    always_comb begin
        slot_valid_d  = {slot_valid_q[LAT-2:0], issue_valid};
        slot_r_d[0]   = rc_addr;
        slot_tag_d[0] = issue_tag;
        slot_key_d[0] = issue_key;
        for (int unsigned i = 1; i < LAT; i++) begin
            slot_r_d[i]   = slot_r_q[i-1];
            slot_tag_d[i] = slot_tag_q[i-1];
            slot_key_d[i] = slot_key_q[i-1];
        end
    end

    // Final key addition: both operands are below P, so one conditional subtract suffices.
    always_comb begin
        key_sum     = {1'b0, round_out} + {1'b0, ret_key};
        key_sum_red = key_sum[N_BITS-1:0] - P;
        out_valid_d = finish;
        out_tag_d   = out_tag_q;
        out_hash_d  = out_hash_q;
        if (finish) begin
            out_tag_d  = ret_tag;
            out_hash_d = (key_sum >= {1'b0, P}) ? key_sum_red : key_sum[N_BITS-1:0];
        end
    end

    // State registers; reset discards every in-flight job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid_q <= '0;
            for (int unsigned i = 0; i < LAT; i++) begin
                slot_r_q[i]   <= '0;
                slot_tag_q[i] <= '0;
                slot_key_q[i] <= '0;
            end
            run_q       <= 1'b0;
            round_in_q  <= '0;
            round_rc_q  <= '0;
            round_key_q <= '0;
            out_valid_q <= 1'b0;
            out_tag_q   <= '0;
            out_hash_q  <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            for (int unsigned i = 0; i < LAT; i++) begin
                slot_r_q[i]   <= slot_r_d[i];
                slot_tag_q[i] <= slot_tag_d[i];
                slot_key_q[i] <= slot_key_d[i];
            end
            run_q       <= run_d;
            round_in_q  <= round_in_d;
            round_rc_q  <= round_rc_d;
            round_key_q <= round_key_d;
            out_valid_q <= out_valid_d;
            out_tag_q   <= out_tag_d;
            out_hash_q  <= out_hash_d;
        end
    end

    assign round_in  = round_in_q;
    assign round_rc  = round_rc_q;
    assign round_key = round_key_q;
    assign out_valid = out_valid_q;
    assign out_tag   = out_tag_q;
    assign out_hash  = out_hash_q;
    assign busy      = (|slot_valid_q) | out_valid_q;

endmodule

// File: tb/tb_mimc_round_scheduler.sv
// tb_mimc_round_scheduler: drives two schedulers (91 rounds and 1 round), each
// with a behavioural round unit and constant ROM, and scores results against
// an independent MiMC golden model through expected-result queues.
module tb_mimc_round_scheduler;

    localparam int unsigned NR = 91;
    localparam int unsigned N1 = 1;
    localparam int unsigned L  = 40;
    localparam logic [253:0] PR = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
    localparam logic [253:0] RC_SEED = 254'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1;

    typedef struct {
        logic [5:0]   tag;
        logic [253:0] hash;
        int unsigned  due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sel = 1'b0;
    logic force1 = 1'b0;
    logic in_valid = 1'b0;
    logic [5:0] in_tag = '0;
    logic [253:0] in_msg = '0;
    logic [253:0] in_key = '0;

    logic in_valid0, in_ready0, out_valid0, busy0;
    logic [6:0] rc_addr0;
    logic [5:0] out_tag0;
    logic [253:0] rc_data0, round_in0, round_rc0, round_key0, round_out0, out_hash0;
    logic in_valid1, in_ready1, out_valid1, busy1;
    logic [6:0] rc_addr1;
    logic [5:0] out_tag1;
    logic [253:0] rc_data1, round_in1, round_rc1, round_key1, round_out1, out_hash1;
    logic in_ready_s;

    logic [253:0] rom [0:127];
    logic [253:0] pipe0 [0:L-2];
    logic [253:0] pipe1 [0:L-2];

    exp_t sb0[$];
    exp_t sb1[$];
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned ov0 = 0;
    int unsigned ov1 = 0;
    logic [6:0] rc_max = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign in_valid0  = in_valid & ~sel;
    assign in_valid1  = in_valid & sel;
    assign in_ready_s = sel ? in_ready1 : in_ready0;
    assign rc_data0   = rom[rc_addr0];
    assign rc_data1   = rom[rc_addr1];
    assign round_out0 = pipe0[L-2];
    assign round_out1 = force1 ? PR - 254'd1 : pipe1[L-2];

    mimc_round_scheduler #(.N_BITS(254), .P(PR), .N_ROUNDS(NR), .ROUND_LATENCY(L), .TAG_W(6), .RC_AW(7)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0), .in_tag(in_tag),
        .in_msg(in_msg), .in_key(in_key), .rc_addr(rc_addr0), .rc_data(rc_data0), .round_in(round_in0),
        .round_rc(round_rc0), .round_key(round_key0), .round_out(round_out0), .out_valid(out_valid0),
        .out_tag(out_tag0), .out_hash(out_hash0), .busy(busy0));

    mimc_round_scheduler #(.N_BITS(254), .P(PR), .N_ROUNDS(N1), .ROUND_LATENCY(L), .TAG_W(6), .RC_AW(7)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .in_tag(in_tag),
        .in_msg(in_msg), .in_key(in_key), .rc_addr(rc_addr1), .rc_data(rc_data1), .round_in(round_in1),
        .round_rc(round_rc1), .round_key(round_key1), .round_out(round_out1), .out_valid(out_valid1),
        .out_tag(out_tag1), .out_hash(out_hash1), .busy(busy1));

    function automatic logic [253:0] mulmod(input logic [253:0] a, input logic [253:0] b);
        return 254'((508'(a) * 508'(b)) % 508'(PR));
    endfunction

    function automatic logic [253:0] pow7(input logic [253:0] x);
        logic [253:0] x2, x4, x6;
        x2 = mulmod(x, x);
        x4 = mulmod(x2, x2);
        x6 = mulmod(x4, x2);
        return mulmod(x6, x);
    endfunction

    function automatic logic [253:0] round_fn(input logic [253:0] x, input logic [253:0] k, input logic [253:0] c);
        return pow7(254'((256'(x) + 256'(k) + 256'(c)) % 256'(PR)));
    endfunction

    function automatic logic [253:0] golden(input logic [253:0] msg, input logic [253:0] key, input int unsigned n);
        logic [253:0] x;
        x = msg;
        for (int unsigned r = 0; r < n; r++) x = round_fn(x, key, rom[r]);
        return 254'((255'(x) + 255'(key)) % 255'(PR));
    endfunction

    function automatic logic [253:0] rand_fe();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return 254'(v % 256'(PR));
    endfunction

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = mulmod(254'(i + 1), RC_SEED);
    end

    // Behavioural round units: registered round_* plus L-1 stages gives L cycles per pass.
    always @(posedge clk) begin
        pipe0[0] <= round_fn(round_in0, round_key0, round_rc0);
        pipe1[0] <= round_fn(round_in1, round_key1, round_rc1);
        for (int i = 1; i < L - 1; i++) begin
            pipe0[i] <= pipe0[i-1];
            pipe1[i] <= pipe1[i-1];
        end
    end

    // Scoreboard consumers: each expected result must appear exactly on its due cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rc_addr0 > rc_max) rc_max = rc_addr0;
            if (sb0.size() != 0 && sb0[0].due == cyc) begin
                e = sb0.pop_front();
                checks++;
                if (out_valid0 !== 1'b1 || out_tag0 !== e.tag || out_hash0 !== e.hash) begin
                    errors++;
                    $display("FAIL result0 got valid=%b tag=%0d hash=%h need valid=1 tag=%0d hash=%h",
                             out_valid0, out_tag0, out_hash0, e.tag, e.hash);
                end
            end else if (out_valid0 === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL spurious0 got out_valid=1 tag=%0d at cycle %0d need out_valid=0", out_tag0, cyc);
            end
            if (out_valid0 === 1'b1) ov0++;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb1.size() != 0 && sb1[0].due == cyc) begin
                e = sb1.pop_front();
                checks++;
                if (out_valid1 !== 1'b1 || out_tag1 !== e.tag || out_hash1 !== e.hash) begin
                    errors++;
                    $display("FAIL result1 got valid=%b tag=%0d hash=%h need valid=1 tag=%0d hash=%h",
                             out_valid1, out_tag1, out_hash1, e.tag, e.hash);
                end
            end else if (out_valid1 === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL spurious1 got out_valid=1 tag=%0d at cycle %0d need out_valid=0", out_tag1, cyc);
            end
            if (out_valid1 === 1'b1) ov1++;
        end
    end

    // Called at a negedge; holds in_valid until accepted or budget runs out.
    // acc is the index of the accepting edge; the result is due to be seen
    // just after edge acc + rounds*L, i.e. sampled by edge acc + rounds*L + 1.
    task automatic offer(input logic [5:0] tag, input logic [253:0] msg, input logic [253:0] key,
                         input logic [253:0] exp_hash, input int unsigned budget,
                         output bit ok, output int unsigned acc);
        exp_t e;
        in_valid = 1'b1;
        in_tag = tag;
        in_msg = msg;
        in_key = key;
        ok = 1'b0;
        acc = 0;
        for (int unsigned i = 0; i < budget; i++) begin
            if (in_ready_s === 1'b1) begin
                acc = cyc + 1;
                e.tag = tag;
                e.hash = exp_hash;
                e.due = acc + (sel ? N1 : NR) * L;
                if (sel) sb1.push_back(e);
                else sb0.push_back(e);
                ok = 1'b1;
            end
            @(negedge clk);
            if (ok) break;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int unsigned budget, input string name);
        int unsigned n;
        n = 0;
        while ((sb0.size() != 0 || sb1.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb0.size() != 0 || sb1.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got %0d results pending need 0", name, sb0.size() + sb1.size());
            sb0.delete();
            sb1.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b need 0", in_ready0); end
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b need 0", out_valid0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b need 0", busy0); end
        checks++; if (out_tag0 !== 6'd0) begin errors++; $display("FAIL reset_out_tag got %0d need 0", out_tag0); end
        checks++; if (out_hash0 !== 254'd0) begin errors++; $display("FAIL reset_out_hash got %h need 0", out_hash0); end
        checks++; if (round_in0 !== 254'd0 || round_rc0 !== 254'd0 || round_key0 !== 254'd0) begin
            errors++; $display("FAIL reset_round got in=%h rc=%h key=%h need 0", round_in0, round_rc0, round_key0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b need 1", in_ready0); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL release_busy1 got %b need 0", busy1); end
    endtask

    task automatic test_single();
        bit ok;
        int unsigned acc, base;
        base = ov0;
        offer(6'd5, '0, '0, golden('0, '0, NR), 10, ok, acc);
        checks++; if (!ok) begin errors++; $display("FAIL single_accept got 0 need 1"); end
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL single_busy got %b need 1", busy0); end
        drain(NR * L + 50, "single");
        checks++; if (ov0 - base != 1) begin errors++; $display("FAIL single_count got %0d need 1", ov0 - base); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL single_idle got %b need 0", busy0); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int unsigned acc, acc0, base;
        logic [253:0] m, k;
        base = ov0;
        acc0 = 0;
        for (int unsigned i = 0; i < 40; i++) begin
            m = 254'(i * 17 + 3);
            k = 254'(i + 1000);
            offer(6'(i), m, k, golden(m, k, NR), 1, ok, acc);
            if (i == 0) acc0 = acc;
            checks++; if (!ok) begin errors++; $display("FAIL b2b_ready job %0d got not accepted need accepted", i); end
        end
        checks++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL b2b_full got in_ready=%b need 0", in_ready0); end
        m = 254'd777;
        k = 254'd42;
        offer(6'd40, m, k, golden(m, k, NR), NR * L + 20, ok, acc);
        checks++; if (!ok || acc != acc0 + NR * L) begin
            errors++; $display("FAIL b2b_41st got accept edge %0d need %0d", acc, acc0 + NR * L);
        end
        drain(NR * L + 100, "b2b");
        checks++; if (ov0 - base != 41) begin errors++; $display("FAIL b2b_count got %0d need 41", ov0 - base); end
    endtask

    task automatic test_short_rounds();
        bit ok;
        int unsigned acc, base;
        base = ov1;
        sel = 1'b1;
        offer(6'd9, 254'd5, 254'd3, golden(254'd5, 254'd3, N1), 10, ok, acc);
        checks++; if (!ok) begin errors++; $display("FAIL short_accept got 0 need 1"); end
        drain(L + 20, "short");
        force1 = 1'b1;
        offer(6'd10, 254'd0, 254'd2, 254'd1, 10, ok, acc);
        checks++; if (!ok) begin errors++; $display("FAIL wrap_accept got 0 need 1"); end
        drain(L + 20, "wrap");
        force1 = 1'b0;
        sel = 1'b0;
        checks++; if (ov1 - base != 2) begin errors++; $display("FAIL short_count got %0d need 2", ov1 - base); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL short_idle got %b need 0", busy1); end
    endtask

    task automatic test_reset_midrun();
        bit ok;
        int unsigned acc, base;
        logic [253:0] m;
        for (int unsigned i = 0; i < 10; i++) begin
            m = 254'(i + 50);
            offer(6'(i + 20), m, m, golden(m, m, NR), 1, ok, acc);
        end
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb0.delete();
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b need 0", busy0); end
        checks++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL midreset_in_ready got %b need 0", in_ready0); end
        base = ov0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (NR * L + 20) @(negedge clk);
        checks++; if (ov0 - base != 0) begin errors++; $display("FAIL midreset_ghost got %0d outputs need 0", ov0 - base); end
        offer(6'd33, 254'd1, 254'd1, golden(254'd1, 254'd1, NR), 10, ok, acc);
        checks++; if (!ok) begin errors++; $display("FAIL midreset_accept got 0 need 1"); end
        drain(NR * L + 50, "midreset");
        checks++; if (ov0 - base != 1) begin errors++; $display("FAIL midreset_count got %0d need 1", ov0 - base); end
    endtask

    task automatic test_random();
        bit ok;
        int unsigned acc, base, idle;
        logic [5:0] t;
        logic [253:0] m, k;
        base = ov0;
        for (int unsigned j = 0; j < 200; j++) begin
            idle = 0;
            while ($urandom_range(0, 1) == 0 && idle < 8) begin
                @(negedge clk);
                idle++;
            end
            t = 6'($urandom_range(0, 63));
            m = rand_fe();
            k = rand_fe();
            offer(t, m, k, golden(m, k, NR), NR * L + 40, ok, acc);
            checks++; if (!ok) begin errors++; $display("FAIL random_accept job %0d got not accepted need accepted", j); end
        end
        drain(NR * L + 100, "random");
        checks++; if (ov0 - base != 200) begin errors++; $display("FAIL random_count got %0d need 200", ov0 - base); end
        checks++; if (rc_max >= 7'(NR)) begin errors++; $display("FAIL rc_addr_range got max %0d need < %0d", rc_max, NR); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL random_idle got %b need 0", busy0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_short_rounds();
        test_reset_midrun();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got no completion need $finish before time limit");
        $fatal(1);
    end

endmodule
